// File: rtl/bomb_fuse.sv
// Single-bomb lifecycle controller: latches the bomb site on set_bomb, runs the
// fuse and blast timers, and publishes map-clipped blast extents while blasting.
module bomb_fuse #(
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30,
    parameter int MAP_W        = 10,
    parameter int MAP_H        = 10
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [2:0] command,
    input  logic [3:0] mapX,
    input  logic [3:0] mapY,
    input  logic [3:0] power,
    output logic [2:0] state,
    output logic [3:0] outx,
    output logic [3:0] outy,
    output logic       blast_active,
    output logic [3:0] blast_xmin,
    output logic [3:0] blast_xmax,
    output logic [3:0] blast_ymin,
    output logic [3:0] blast_ymax
);

    typedef enum logic [2:0] {
        ST_FUSE  = 3'd0,
        ST_BLAST = 3'd1,
        ST_READY = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    localparam logic [2:0] CMD_SET_BOMB = 3'd4;
    localparam logic [7:0] FUSE_LOAD    = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0] BLAST_LOAD   = 8'(BLAST_FRAMES - 1);

    state_t     state_reg, state_next;
    logic [3:0] outx_reg, outx_next;
    logic [3:0] outy_reg, outy_next;
    logic [3:0] rad_reg, rad_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       blast_active_reg, blast_active_next;
    logic [1:0][3:0] ext_min_reg, ext_min_next;
    logic [1:0][3:0] ext_max_reg, ext_max_next;

    // Index 0 is the column axis, index 1 the row axis.
    logic [1:0][3:0] axis_pos;
    logic [1:0][3:0] ext_min_calc;
    logic [1:0][3:0] ext_max_calc;

    assign axis_pos[0] = outx_reg;
    assign axis_pos[1] = outy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [4:0] HI_LIM = (gi == 0) ? 5'(MAP_W - 2) : 5'(MAP_H - 2);
            logic [4:0] lo_diff;
            logic [4:0] hi_sum;

            assign lo_diff = {1'b0, axis_pos[gi]} - {1'b0, rad_reg};
            assign hi_sum  = {1'b0, axis_pos[gi]} + {1'b0, rad_reg};
            // A difference of zero or below would land on (or past) the wall tile.
            assign ext_min_calc[gi] = (axis_pos[gi] <= rad_reg) ? 4'd1 : lo_diff[3:0];
            assign ext_max_calc[gi] = (hi_sum > HI_LIM) ? HI_LIM[3:0] : hi_sum[3:0];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        outx_next         = outx_reg;
        outy_next         = outy_reg;
        rad_next          = rad_reg;
        cnt_next          = cnt_reg;
        blast_active_next = blast_active_reg;
        ext_min_next      = ext_min_reg;
        ext_max_next      = ext_max_reg;

        case (state_reg)
            ST_READY: begin
                if (command == CMD_SET_BOMB) begin
                    outx_next  = mapX;
                    outy_next  = mapY;
                    rad_next   = (power == 4'd0) ? 4'd1 : power;
                    cnt_next   = FUSE_LOAD;
                    state_next = ST_FUSE;
                end
            end
            ST_FUSE: begin
                if (cnt_reg == 8'd0) begin
                    cnt_next          = BLAST_LOAD;
                    ext_min_next      = ext_min_calc;
                    ext_max_next      = ext_max_calc;
                    blast_active_next = 1'b1;
                    state_next        = ST_BLAST;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_BLAST: begin
                if (cnt_reg == 8'd0) begin
                    blast_active_next = 1'b0;
                    state_next        = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_READY;
            end
            default: begin
                state_next = ST_READY;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg        <= ST_READY;
            outx_reg         <= 4'd0;
            outy_reg         <= 4'd0;
            rad_reg          <= 4'd0;
            cnt_reg          <= 8'd0;
            blast_active_reg <= 1'b0;
            ext_min_reg      <= '0;
            ext_max_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            outx_reg         <= outx_next;
            outy_reg         <= outy_next;
            rad_reg          <= rad_next;
            cnt_reg          <= cnt_next;
            blast_active_reg <= blast_active_next;
            ext_min_reg      <= ext_min_next;
            ext_max_reg      <= ext_max_next;
        end
    end

    assign state        = state_reg;
    assign outx         = outx_reg;
    assign outy         = outy_reg;
    assign blast_active = blast_active_reg;
    assign blast_xmin   = ext_min_reg[0];
    assign blast_xmax   = ext_max_reg[0];
    assign blast_ymin   = ext_min_reg[1];
    assign blast_ymax   = ext_max_reg[1];

endmodule
